// File: rtl/timer_pkg.sv
// Register map, control/status bit positions and prescaler encodings shared by
// the multi-channel APB timer and its per-channel counter slices.
package timer_pkg;

  localparam int CH_STRIDE = 16;

  localparam logic [3:0] OFF_TDR  = 4'h0;
  localparam logic [3:0] OFF_TCR  = 4'h4;
  localparam logic [3:0] OFF_TSR  = 4'h8;
  localparam logic [3:0] OFF_TCNT = 4'hC;

  localparam int TCR_CKS_LO = 0;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_EN     = 4;
  localparam int TCR_UD     = 5;
  localparam int TCR_AR     = 6;
  localparam int TCR_LOAD   = 7;
  localparam int TCR_IE     = 8;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [1:0] {
    CKS_DIV1 = 2'b00,
    CKS_DIV2 = 2'b01,
    CKS_DIV4 = 2'b10,
    CKS_DIV8 = 2'b11
  } cks_e;

  // Prescaler fires on the last phase of its 1/2/4/8-cycle period.
  function automatic logic presc_tick(cks_e cks, logic [2:0] pre);
    logic t;
    case (cks)
      CKS_DIV1: t = 1'b1;
      CKS_DIV2: t = pre[0];
      CKS_DIV4: t = &pre[1:0];
      default:  t = &pre;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up/down counter with auto-reload, W1C flags and
// registered irq. Register writes take effect on the commit edge; never stalls.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        wr,
  input  logic [3:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rd_dat,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] tdr, cnt;
  cks_e             cks;
  logic             en, ud, ar, ie, ovf, udf;
  logic [2:0]       pre;
  logic             wr_tdr, wr_tcr, wr_tsr, load, tick, wrap_up, wrap_dn;
  logic             unused_wdata;

  assign unused_wdata = ^wdata;

  assign wr_tdr  = wr && (off == OFF_TDR);
  assign wr_tcr  = wr && (off == OFF_TCR);
  assign wr_tsr  = wr && (off == OFF_TSR);
  assign load    = wr_tcr && wdata[TCR_LOAD];
  assign tick    = en && presc_tick(cks, pre);
  // A load on the same edge swallows the tick, including its flag.
  assign wrap_up = tick && !load && !ud && (cnt == CNT_MAX);
  assign wrap_dn = tick && !load &&  ud && (cnt == '0);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr <= '0;
      cnt <= '0;
      cks <= CKS_DIV1;
      en  <= 1'b0;
      ud  <= 1'b0;
      ar  <= 1'b0;
      ie  <= 1'b0;
      pre <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_tdr) tdr <= wdata[CNT_W-1:0];
      if (wr_tcr) begin
        cks <= cks_e'(wdata[TCR_CKS_HI:TCR_CKS_LO]);
        en  <= wdata[TCR_EN];
        ud  <= wdata[TCR_UD];
        ar  <= wdata[TCR_AR];
        ie  <= wdata[TCR_IE];
      end
      pre <= en ? pre + 3'd1 : 3'd0;

      if (load)         cnt <= tdr;
      else if (wrap_up) cnt <= ar ? tdr : '0;
      else if (wrap_dn) cnt <= ar ? tdr : CNT_MAX;
      else if (tick)    cnt <= ud ? cnt - CNT_ONE : cnt + CNT_ONE;

      ovf <= wrap_up | (ovf & ~(wr_tsr & wdata[TSR_OVF]));
      udf <= wrap_dn | (udf & ~(wr_tsr & wdata[TSR_UDF]));
      irq <= ie & (ovf | udf);
    end
  end

  always_comb begin
    rd_dat = '0;
    case (off)
      OFF_TDR:  rd_dat[CNT_W-1:0] = tdr;
      OFF_TCR: begin
        rd_dat[TCR_CKS_HI:TCR_CKS_LO] = cks;
        rd_dat[TCR_EN] = en;
        rd_dat[TCR_UD] = ud;
        rd_dat[TCR_AR] = ar;
        rd_dat[TCR_IE] = ie;
      end
      OFF_TSR: begin
        rd_dat[TSR_OVF] = ovf;
        rd_dat[TSR_UDF] = udf;
      end
      OFF_TCNT: rd_dat[CNT_W-1:0] = cnt;
      default:  rd_dat = '0;
    endcase
  end

endmodule

// File: rtl/apb_timer_multi.sv
// APB front end for NUM_CH timer channels: decode, wait-state counter, read mux.
// pready after WAIT_CYCLES access cycles; writes commit on the edge ending pready.
module apb_timer_multi
  import timer_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq
);

  localparam int         CH_SHIFT  = $clog2(CH_STRIDE);
  localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYCLES);

  logic [7-CH_SHIFT:0]  ch_idx;
  logic [CH_SHIFT-1:0]  off;
  logic [1:0]           wait_cnt;
  logic                 access, ready, off_ok, ch_ok, err, commit;
  logic [31:0]          ch_rd [NUM_CH];
  logic [31:0]          rd_sel;

  assign ch_idx = paddr[7:CH_SHIFT];
  assign off    = paddr[CH_SHIFT-1:0];
  assign access = psel && penable;
  // Gating with presetn drops pready combinationally when a transfer is reset.
  assign ready  = presetn && access && (wait_cnt == WAIT_LAST);
  assign off_ok = off inside {OFF_TDR, OFF_TCR, OFF_TSR, OFF_TCNT};
  assign ch_ok  = int'(ch_idx) < NUM_CH;
  assign err    = !off_ok || !ch_ok || (pwrite && (off == OFF_TCNT));
  assign commit = ready && pwrite && !err;

  assign pready  = ready;
  assign pslverr = ready && err;
  assign prdata  = (ready && !pwrite && !err) ? rd_sel : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)             wait_cnt <= '0;
    else if (!psel || ready)  wait_cnt <= '0;
    else if (access)          wait_cnt <= wait_cnt + 2'd1;
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch_idx) == i) rd_sel = ch_rd[i];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .pclk    (pclk),
      .presetn (presetn),
      .wr      (commit && (int'(ch_idx) == c)),
      .off     (off),
      .wdata   (pwdata),
      .rd_dat  (ch_rd[c]),
      .irq     (irq[c])
    );
  end

endmodule

// File: tb/tb_apb_timer_multi.sv
// Directed bench for apb_timer_multi: a WAIT_CYCLES=2 instance carries the
// timer scenarios, a zero-wait instance covers the fast handshake.
module tb_apb_timer_multi;

  localparam int NUM_CH = 2;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  logic              psel_a = 1'b0, penable_a = 1'b0, pwrite_a = 1'b0;
  logic [7:0]        paddr_a = '0;
  logic [31:0]       pwdata_a = '0;
  logic [31:0]       prdata_a;
  logic              pready_a, pslverr_a;
  logic [NUM_CH-1:0] irq_a;

  logic              psel_b = 1'b0, penable_b = 1'b0, pwrite_b = 1'b0;
  logic [7:0]        paddr_b = '0;
  logic [31:0]       pwdata_b = '0;
  logic [31:0]       prdata_b;
  logic              pready_b, pslverr_b;
  logic [NUM_CH-1:0] irq_b;

  apb_timer_multi #(.NUM_CH(NUM_CH), .CNT_W(8), .WAIT_CYCLES(2)) dut_a (
    .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable_a),
    .pwrite(pwrite_a), .paddr(paddr_a), .pwdata(pwdata_a), .prdata(prdata_a),
    .pready(pready_a), .pslverr(pslverr_a), .irq(irq_a)
  );

  apb_timer_multi #(.NUM_CH(NUM_CH), .CNT_W(8), .WAIT_CYCLES(0)) dut_b (
    .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable_b),
    .pwrite(pwrite_b), .paddr(paddr_b), .pwdata(pwdata_b), .prdata(prdata_b),
    .pready(pready_b), .pslverr(pslverr_b), .irq(irq_b)
  );

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int e0 = 0;
  int e1 = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counter value after edge k. 1: ch0 counting up from 0xFD since edge e0,
  // one tick per cycle. 2: ch1 counting down from 5 every 4 cycles, reloading 5.
  function automatic logic [31:0] model_val(int mid, int k);
    logic [7:0] v;
    int n;
    v = 8'h00;
    if (mid == 1) begin
      v = 8'hFD + 8'(k - e0);
    end else if (mid == 2) begin
      n = (k - e1) / 4;
      v = 8'(5 - (n % 6));
    end
    return {24'h0, v};
  endfunction

  task automatic wait_until(input int k);
    @(negedge pclk);
    if (cyc > k) begin
      errors++;
      $error("FAIL sched: cycle %0d already past target %0d", cyc, k);
    end
    while (cyc < k) @(negedge pclk);
  endtask

  // One APB transfer; returns the index of the edge that ends the pready cycle.
  task automatic xfer(input bit b, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wd, input int mid, input logic [31:0] exp_rd,
                      input bit exp_err, input string tag, output int commit);
    exp_t e, got;
    int   c, n, w;
    logic rdy;
    w = b ? 0 : 2;
    @(negedge pclk);
    c = cyc;
    e.rd  = (wr || exp_err) ? 32'h0 : ((mid != 0) ? model_val(mid, c + 1 + w) : exp_rd);
    e.err = exp_err;
    sb.push_back(e);
    if (b) begin
      psel_b = 1'b1; penable_b = 1'b0; pwrite_b = wr; paddr_b = addr; pwdata_b = wd;
    end else begin
      psel_a = 1'b1; penable_a = 1'b0; pwrite_a = wr; paddr_a = addr; pwdata_a = wd;
    end
    @(negedge pclk);
    if (b) penable_b = 1'b1; else penable_a = 1'b1;
    #1;
    n = 1;
    rdy = b ? pready_b : pready_a;
    while (!rdy && n < 8) begin
      @(negedge pclk);
      #1;
      n++;
      rdy = b ? pready_b : pready_a;
    end
    got = sb.pop_front();
    check({tag, " wait"}, n, w + 1);
    check({tag, " prdata"}, b ? prdata_b : prdata_a, got.rd);
    check({tag, " pslverr"}, 32'(b ? pslverr_b : pslverr_a), 32'(got.err));
    @(posedge pclk);
    #1;
    commit = cyc;
    psel_a = 1'b0; penable_a = 1'b0;
    psel_b = 1'b0; penable_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cm, wr_edge;
    logic [7:0] a;

    // Reset values
    repeat (3) @(negedge pclk);
    check("rst pready_a", 32'(pready_a), 32'h0);
    check("rst pslverr_a", 32'(pslverr_a), 32'h0);
    check("rst prdata_a", prdata_a, 32'h0);
    check("rst irq_a", 32'(irq_a), 32'h0);
    presetn = 1'b1;

    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int o = 0; o < 4; o++) begin
        a = 8'(ch * 16 + o * 4);
        xfer(0, 0, a, 32'h0, 0, 32'h0, 0, $sformatf("rst rd %02h", a), cm);
      end
    end
    xfer(0, 0, 8'h2C, 32'h0, 0, 32'h0, 1, "rd bad ch", cm);
    xfer(0, 0, 8'h02, 32'h0, 0, 32'h0, 1, "rd bad off", cm);

    // Zero-wait instance
    xfer(1, 1, 8'h00, 32'h5A, 0, 32'h0, 0, "b wr tdr", cm);
    xfer(1, 0, 8'h00, 32'h0, 0, 32'h5A, 0, "b rd tdr", cm);

    // Ch0 up count from 0xFD with irq
    xfer(0, 1, 8'h00, 32'hFD, 0, 32'h0, 0, "wr tdr0", cm);
    xfer(0, 1, 8'h04, 32'h190, 0, 32'h0, 0, "wr tcr0", cm);
    e0 = cm;
    wait_until(e0 + 3);
    check("irq0 before", 32'(irq_a[0]), 32'h0);
    wait_until(e0 + 4);
    check("irq0 after wrap", 32'(irq_a[0]), 32'h1);
    xfer(0, 0, 8'h08, 32'h0, 0, 32'h1, 0, "rd tsr0 ovf", cm);
    xfer(0, 0, 8'h04, 32'h0, 0, 32'h110, 0, "rd tcr0", cm);
    xfer(0, 0, 8'h0C, 32'h0, 1, 32'h0, 0, "rd tcnt0 a", cm);

    // W1C clears ovf, irq follows one cycle later
    xfer(0, 1, 8'h08, 32'h1, 0, 32'h0, 0, "w1c tsr0", cm);
    check("irq0 at clear", 32'(irq_a[0]), 32'h1);
    wait_until(cm + 1);
    check("irq0 cleared", 32'(irq_a[0]), 32'h0);
    xfer(0, 0, 8'h08, 32'h0, 0, 32'h0, 0, "rd tsr0 clr", cm);

    // Errored writes change nothing
    xfer(0, 1, 8'h0C, 32'h33, 0, 32'h0, 1, "wr tcnt0", cm);
    xfer(0, 0, 8'h0C, 32'h0, 1, 32'h0, 0, "rd tcnt0 b", cm);
    xfer(0, 1, 8'h20, 32'h77, 0, 32'h0, 1, "wr bad ch", cm);
    xfer(0, 0, 8'h00, 32'h0, 0, 32'hFD, 0, "rd tdr0 kept", cm);

    // Ch1 down, auto-reload 5, divide by 4
    xfer(0, 1, 8'h10, 32'h5, 0, 32'h0, 0, "wr tdr1", cm);
    xfer(0, 1, 8'h14, 32'hF2, 0, 32'h0, 0, "wr tcr1", cm);
    e1 = cm;
    xfer(0, 0, 8'h1C, 32'h0, 2, 32'h0, 0, "rd tcnt1 a", cm);
    xfer(0, 0, 8'h1C, 32'h0, 2, 32'h0, 0, "rd tcnt1 b", cm);
    wait_until(e1 + 21);
    xfer(0, 0, 8'h1C, 32'h0, 2, 32'h0, 0, "rd tcnt1 reload", cm);
    xfer(0, 0, 8'h18, 32'h0, 0, 32'h2, 0, "rd tsr1 udf", cm);
    xfer(0, 0, 8'h0C, 32'h0, 1, 32'h0, 0, "rd tcnt0 c", cm);
    check("irq1 masked", 32'(irq_a[1]), 32'h0);

    // W1C landing on a wrap edge: the new flag survives
    wr_edge = e0 + 3;
    while (wr_edge < cyc + 8) wr_edge += 256;
    wait_until(wr_edge - 5);
    xfer(0, 1, 8'h08, 32'h1, 0, 32'h0, 0, "w1c on wrap", cm);
    xfer(0, 0, 8'h08, 32'h0, 0, 32'h1, 0, "rd tsr0 set wins", cm);

    // Load on a tick edge (cks=00 ticks every cycle)
    xfer(0, 1, 8'h04, 32'h190, 0, 32'h0, 0, "load on tick", cm);
    e0 = cm;
    xfer(0, 0, 8'h0C, 32'h0, 1, 32'h0, 0, "rd tcnt0 load", cm);

    // Reset in the middle of a zero-wait access
    @(negedge pclk);
    psel_b = 1'b1; pwrite_b = 1'b0; paddr_b = 8'h00;
    @(negedge pclk);
    penable_b = 1'b1;
    #1;
    check("b pready before rst", 32'(pready_b), 32'h1);
    presetn = 1'b0;
    #1;
    check("b pready in rst", 32'(pready_b), 32'h0);
    check("b prdata in rst", prdata_b, 32'h0);
    check("irq in rst", 32'(irq_a), 32'h0);
    psel_b = 1'b0; penable_b = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    repeat (5) @(negedge pclk);
    xfer(0, 0, 8'h0C, 32'h0, 0, 32'h0, 0, "post rst tcnt0", cm);
    xfer(0, 0, 8'h04, 32'h0, 0, 32'h0, 0, "post rst tcr0", cm);
    xfer(0, 0, 8'h08, 32'h0, 0, 32'h0, 0, "post rst tsr0", cm);
    xfer(0, 0, 8'h00, 32'h0, 0, 32'h0, 0, "post rst tdr0", cm);
    xfer(0, 0, 8'h1C, 32'h0, 0, 32'h0, 0, "post rst tcnt1", cm);
    xfer(1, 0, 8'h00, 32'h0, 0, 32'h0, 0, "b post rst tdr0", cm);
    check("post rst irq", 32'(irq_a), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_timer_multi.md
# apb_timer_multi

Parametrised multi-channel APB timer: NUM_CH independent up/down counters of CNT_W bits with per-channel prescaler, auto-reload, write-1-to-clear status flags and maskable interrupts, behind one APB slave with programmable wait states. It is the next-generation replacement for the single 8-bit timer register block and sits on the peripheral APB bus, driving the interrupt controller.

## Interface
- NUM_CH, 2, number of channels, 1..4
- CNT_W, 8, counter/reload width, 8..16
- WAIT_CYCLES, 2, access-phase wait states before pready, 0..3
- pclk  in  1  APB clock; all logic on rising edge
- presetn  in  1  asynchronous, active-low reset
- psel  in  1  slave select
- penable  in  1  access phase
- pwrite  in  1  1 = write
- paddr  in  8  byte address
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  transfer complete
- pslverr  out  1  error, valid with pready
- irq  out  NUM_CH  per-channel level interrupt

## Operation
- Address map: channel c at base 0x10*c. Offsets: 0x0 TDR (reload, RW), 0x4 TCR (RW), 0x8 TSR (RW1C), 0xC TCNT (RO).
- TCR bits: [1:0] cks, [4] en, [5] ud (0 up, 1 down), [6] ar (auto-reload), [7] load (self-clearing, reads 0), [8] ie. Other bits read 0.
- TSR bits: [0] ovf, [1] udf. Writing 1 clears; writing 0 no effect.
- Prescaler: 3-bit per channel, held at 0 while en=0. Tick every 1/2/4/8 pclk for cks 00/01/10/11.
- Up count: on tick, TCNT==max wraps to 0 (ar=0) or TDR (ar=1), sets ovf. Down: TCNT==0 wraps to max (ar=0) or TDR (ar=1), sets udf. Otherwise ±1.
- Writing TCR with load=1 copies TDR (current value, before any same-cycle TDR write) into TCNT on the commit edge; load beats a same-cycle tick.
- Flag set and W1C clear in the same cycle: set wins.
- irq[c] registered: irq[c] <= ie[c] & (ovf[c] | udf[c]).
- pslverr=1: offset not in map, channel index >= NUM_CH, or write to TCNT. Errored writes change nothing; errored reads return 0.
- prdata is 0 except in the pready cycle of a read.

## Timing
- Reset: all registers, counters, prescalers, flags, irq, pready, pslverr, prdata = 0.
- APB: setup phase (psel & !penable), then access. pready low for first WAIT_CYCLES access cycles, high in cycle WAIT_CYCLES+1 (WAIT_CYCLES=0: zero-wait). Wait counter returns to 0 after pready and whenever psel=0.
- Write commits on the edge ending the pready cycle; register readable in next transfer.
- Flags set on the edge where the wrapping tick occurs; irq rises one cycle later.
- Counter runs during APB stalls; TCNT read returns value at the pready cycle.
- presetn assertion mid-transfer aborts it; pready drops immediately.

## Structure
- Package timer_pkg: register offsets, TCR/TSR bit indices, cks encodings, channel stride.
- Sub-module timer_channel (prescaler, counter, flags, irq), instantiated NUM_CH times; top holds APB decode, wait counter, read mux.

## Test plan
- Reset, read all channels' TDR/TCR/TSR/TCNT -> all 0, pslverr=0; read 0x0C with NUM_CH=2 at 0x2C -> pslverr=1, prdata 0.
- WAIT_CYCLES=2 write -> pready high exactly 3rd access cycle; WAIT_CYCLES=0 -> first access cycle.
- Ch0 TDR=0xFD, TCR=load|en|cks=00 up -> TCNT 0xFD,0xFE,0xFF,0x00, ovf=1 at wrap; ie=1 -> irq[0] one cycle later; W1C 0x1 -> ovf=0, irq drops.
- Ch1 down, ar=1, TDR=0x05, cks=10 -> decrements every 4 pclk, 0 reloads 0x05, udf=1; ch0 unaffected.
- W1C of ovf on same edge as new wrap -> ovf stays 1; load write on tick edge -> TCNT=TDR.
- Write TCNT -> pslverr=1, TCNT unchanged; mid-count presetn pulse -> all state 0.
